// File: rtl/tree_sum_accumulator_pkg.sv
// Shared types and constants for the LSD tree sum accumulator.
// clog2 matches the one used by the adder tree so the sideband delay lines up with the tree.
package tree_sum_accumulator_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

  typedef struct packed {
    logic valid;
    logic last;
  } sideband_t;

endpackage

// File: rtl/tree_sum_accumulator_sideband_delay.sv
// DEPTH-stage resettable register chain for beat sideband; a plain wire when DEPTH is 0.
module sideband_delay #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_clock_reset;
      assign unused_clock_reset = clock ^ reset;
      assign data_out = data_in;
    end else begin : g_chain
      logic [WIDTH-1:0] stage_q [DEPTH];

      always_ff @(posedge clock) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
          end
        end else begin
          stage_q[0] <= data_in;
          for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
          end
        end
      end

      assign data_out = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/tree_sum_accumulator.sv
// Accumulates adder-tree sums over last-terminated groups and hands the saturated total,
// beat count and overflow flag to a one-entry valid/ready output register.
module tree_sum_accumulator
  import tree_sum_accumulator_pkg::*;
#(
  parameter int unsigned IN_NUM    = 4,
  parameter int unsigned BIT_WIDTH = 8,
  parameter int unsigned ACC_WIDTH = 16,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic [BIT_WIDTH-1:0] sum_value,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_overflow,
  output logic                 overrun
);

  localparam int unsigned ADD_DEPTH = clog2(IN_NUM);

  sideband_t sb_in;
  sideband_t sb_aligned;
  logic      a_valid;
  logic      a_last;

  // last is gated by valid so an idle cycle can never close a group
  assign sb_in.valid = in_valid;
  assign sb_in.last  = in_valid & in_last;

  sideband_delay #(
    .DEPTH(ADD_DEPTH),
    .WIDTH($bits(sideband_t))
  ) u_sideband_delay (
    .clock    (clock),
    .reset    (reset),
    .data_in  (sb_in),
    .data_out (sb_aligned)
  );

  assign a_valid = sb_aligned.valid;
  assign a_last  = sb_aligned.last;

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0] out_sum_q, out_sum_d;
  logic [CNT_WIDTH-1:0] out_count_q, out_count_d;
  logic                 out_overflow_q, out_overflow_d;
  logic                 overrun_q, overrun_d;

  logic [ACC_WIDTH:0]   sum_ext;
  logic [ACC_WIDTH:0]   sum_wide;
  logic                 sum_sat;
  logic                 cnt_sat;
  logic [ACC_WIDTH-1:0] nsum;
  logic [CNT_WIDTH-1:0] ncnt;
  logic                 novf;
  logic                 group_done;
  logic                 accept;
  logic                 load;

  assign sum_ext  = {{(ACC_WIDTH + 1 - BIT_WIDTH){1'b0}}, sum_value};
  assign sum_wide = {1'b0, acc_q} + sum_ext;
  assign sum_sat  = sum_wide[ACC_WIDTH];
  assign nsum     = sum_sat ? '1 : sum_wide[ACC_WIDTH-1:0];
  assign cnt_sat  = &cnt_q;
  assign ncnt     = cnt_sat ? cnt_q : cnt_q + 1'b1;
  assign novf     = ovf_q | sum_sat | cnt_sat;

  assign group_done = a_valid & a_last;
  assign accept     = out_valid_q & out_ready;
  assign load       = group_done & (~out_valid_q | out_ready);

  always_comb begin
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    ovf_d          = ovf_q;
    out_valid_d    = out_valid_q;
    out_sum_d      = out_sum_q;
    out_count_d    = out_count_q;
    out_overflow_d = out_overflow_q;
    overrun_d      = 1'b0;

    if (a_valid) begin
      if (a_last) begin
        acc_d = '0;
        cnt_d = '0;
        ovf_d = 1'b0;
      end else begin
        acc_d = nsum;
        cnt_d = ncnt;
        ovf_d = novf;
      end
    end

    if (accept) begin
      out_valid_d = 1'b0;
    end

    // A load on the accept edge is a back-to-back transfer and keeps out_valid high
    if (load) begin
      out_valid_d    = 1'b1;
      out_sum_d      = nsum;
      out_count_d    = ncnt;
      out_overflow_d = novf;
    end else if (group_done) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q          <= '0;
      cnt_q          <= '0;
      ovf_q          <= 1'b0;
      out_valid_q    <= 1'b0;
      out_sum_q      <= '0;
      out_count_q    <= '0;
      out_overflow_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      ovf_q          <= ovf_d;
      out_valid_q    <= out_valid_d;
      out_sum_q      <= out_sum_d;
      out_count_q    <= out_count_d;
      out_overflow_q <= out_overflow_d;
      overrun_q      <= overrun_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_sum      = out_sum_q;
  assign out_count    = out_count_q;
  assign out_overflow = out_overflow_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_tree_sum_accumulator.sv
// Directed bench: a 4-input (delay 2, 12-bit acc) instance plus a 1-input (delay 0) instance.
module tb_tree_sum_accumulator;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        in_valid, in_last, out_ready;
  logic [7:0]  beat_sum, tree_d1, sum_value;
  logic        out_valid, out_overflow, overrun;
  logic [11:0] out_sum;
  logic [7:0]  out_count;

  logic        in_valid1, in_last1, out_ready1;
  logic [7:0]  sum_value1;
  logic        out_valid1, out_overflow1, overrun1;
  logic [15:0] out_sum1;
  logic [7:0]  out_count1;

  tree_sum_accumulator #(
    .IN_NUM(4), .BIT_WIDTH(8), .ACC_WIDTH(12), .CNT_WIDTH(8)
  ) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_last(in_last),
    .sum_value(sum_value), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_overflow(out_overflow),
    .overrun(overrun)
  );

  tree_sum_accumulator #(
    .IN_NUM(1), .BIT_WIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(8)
  ) dut1 (
    .clock(clock), .reset(reset), .in_valid(in_valid1), .in_last(in_last1),
    .sum_value(sum_value1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_sum(out_sum1), .out_count(out_count1), .out_overflow(out_overflow1),
    .overrun(overrun1)
  );

  // Behavioural two-level adder tree: the sum trails its inputs by two cycles
  always @(posedge clock) begin
    if (reset) begin
      tree_d1   <= 8'd0;
      sum_value <= 8'd0;
    end else begin
      tree_d1   <= beat_sum;
      sum_value <= tree_d1;
    end
  end

  typedef struct {
    logic [11:0] sum;
    logic [7:0]  cnt;
    logic        ovf;
  } res_t;

  res_t got_q[$];
  int   overrun_cnt = 0;

  always @(negedge clock) begin
    if (!reset) begin
      if (out_valid && out_ready) got_q.push_back('{out_sum, out_count, out_overflow});
      if (overrun) overrun_cnt++;
    end
  end

  int pass_count  = 0;
  int total_count = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    total_count++;
    if (actual === expected) pass_count++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic beat(input logic [7:0] val, input logic last);
    in_valid = 1'b1;
    in_last  = last;
    beat_sum = val;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    beat_sum = 8'd0;
  endtask

  task automatic expect_result(input string name, input int exp_sum, input int exp_cnt,
                               input int exp_ovf);
    int   waited;
    res_t r;
    waited = 0;
    while (got_q.size() == 0 && waited < 40) begin
      @(posedge clock);
      #1;
      waited++;
    end
    if (got_q.size() == 0) begin
      check({name, " timeout"}, 32'd0, 32'd1);
    end else begin
      r = got_q.pop_front();
      check({name, " sum"}, 32'(r.sum), 32'(exp_sum));
      check({name, " count"}, 32'(r.cnt), 32'(exp_cnt));
      check({name, " overflow"}, 32'(r.ovf), 32'(exp_ovf));
    end
  endtask

  typedef struct {
    string name;
    int    n;
    int    start;
    int    step;
    int    gaps;
    int    exp_sum;
    int    exp_cnt;
    int    exp_ovf;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat;
    int ovr0;

    vecs[0] = '{"sat 17x255",   17, 255, 0, 0, 4095,  17, 1};
    vecs[1] = '{"after sat 1",   1,   1, 0, 0,    1,   1, 0};
    vecs[2] = '{"16x255 edge",  16, 255, 0, 0, 4080,  16, 0};
    vecs[3] = '{"4x100 gapped",  4, 100, 0, 1,  400,   4, 0};
    vecs[4] = '{"ramp 1..5",     5,   1, 1, 2,   15,   5, 0};
    vecs[5] = '{"count sat",   256,   0, 0, 0,    0, 255, 1};

    reset = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; beat_sum = 8'd0; out_ready = 1'b1;
    in_valid1 = 1'b0; in_last1 = 1'b0; sum_value1 = 8'd0; out_ready1 = 1'b1;
    idle(3);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_sum", 32'(out_sum), 32'd0);
    check("reset out_count", 32'(out_count), 32'd0);
    check("reset out_overflow", 32'(out_overflow), 32'd0);
    check("reset overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    idle(2);

    // Basic group with latency check: last consumed on edge 1, visible after edge 3
    beat(8'd10, 1'b0);
    beat(8'd20, 1'b0);
    beat(8'd30, 1'b1);
    lat = 1;
    while (!out_valid && lat < 10) begin
      idle(1);
      lat++;
    end
    check("basic latency", 32'(lat), 32'd3);
    check("basic out_sum direct", 32'(out_sum), 32'd60);
    expect_result("basic", 60, 3, 0);

    // Gaps inside a group, then an immediate single-beat group
    beat(8'd5, 1'b0);
    idle(2);
    beat(8'd7, 1'b1);
    beat(8'd9, 1'b1);
    expect_result("gap group", 12, 2, 0);
    expect_result("single beat", 9, 1, 0);
    idle(4);
    check("gap no extra", 32'(got_q.size()), 32'd0);

    // Backpressure: second completion is dropped with a single overrun pulse
    out_ready = 1'b0;
    beat(8'd10, 1'b0);
    beat(8'd20, 1'b0);
    beat(8'd30, 1'b1);
    idle(5);
    check("bp pending valid", 32'(out_valid), 32'd1);
    ovr0 = overrun_cnt;
    beat(8'd5, 1'b1);
    idle(5);
    check("bp overrun pulses", 32'(overrun_cnt - ovr0), 32'd1);
    check("bp sum held", 32'(out_sum), 32'd60);
    check("bp count held", 32'(out_count), 32'd3);
    out_ready = 1'b1;
    expect_result("bp drained", 60, 3, 0);
    idle(3);

    // Back-to-back: consumer accepts on the very edge the next group completes
    out_ready = 1'b0;
    beat(8'd7, 1'b1);
    idle(4);
    ovr0 = overrun_cnt;
    beat(8'd8, 1'b1);
    idle(1);
    out_ready = 1'b1;
    idle(1);
    check("b2b valid kept", 32'(out_valid), 32'd1);
    check("b2b new data", 32'(out_sum), 32'd8);
    expect_result("b2b first", 7, 1, 0);
    expect_result("b2b second", 8, 1, 0);
    idle(3);
    check("b2b no overrun", 32'(overrun_cnt - ovr0), 32'd0);

    // Reset mid-group discards the partial sum
    beat(8'd100, 1'b0);
    beat(8'd100, 1'b0);
    idle(2);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    beat(8'd3, 1'b1);
    expect_result("post reset", 3, 1, 0);

    // A completed beat still in the delay line is flushed by reset
    beat(8'd50, 1'b1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(6);
    check("flush out_valid", 32'(out_valid), 32'd0);
    check("flush no result", 32'(got_q.size()), 32'd0);

    foreach (vecs[k]) begin
      for (int i = 0; i < vecs[k].n; i++) begin
        if (i > 0) idle(vecs[k].gaps);
        beat(8'(vecs[k].start + i * vecs[k].step), i == vecs[k].n - 1);
      end
      expect_result(vecs[k].name, vecs[k].exp_sum, vecs[k].exp_cnt, vecs[k].exp_ovf);
    end

    // Zero-delay instance: result visible one edge after the beat
    in_valid1 = 1'b1; in_last1 = 1'b1; sum_value1 = 8'd42;
    idle(1);
    in_valid1 = 1'b0; in_last1 = 1'b0; sum_value1 = 8'd0;
    check("d0 out_valid", 32'(out_valid1), 32'd1);
    check("d0 out_sum", 32'(out_sum1), 32'd42);
    check("d0 out_count", 32'(out_count1), 32'd1);
    idle(1);
    check("d0 accepted", 32'(out_valid1), 32'd0);

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule

// File: doc/tree_sum_accumulator.md
Name: tree_sum_accumulator

Overview:
Downstream consumer of the LSD adder tree. It takes the tree's per-cycle sum together with valid/last sideband presented alongside the tree's inputs, and delays that sideband by the tree's latency so it lines up with the sum. It accumulates aligned sums over a group of beats terminated by `last`, then presents the group total, beat count and overflow flag through a one-entry valid/ready output register. Typical use: gradient/support sums over a line-segment region.

Parameters:
IN_NUM, 4, number of tree inputs; sets sideband delay ADD_DEPTH = ceil(log2(IN_NUM)), 0 when IN_NUM==1
BIT_WIDTH, 8, width of sum_value (unsigned)
ACC_WIDTH, 16, accumulator / out_sum width; must be >= BIT_WIDTH
CNT_WIDTH, 8, beat counter / out_count width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  beat valid, presented in the same cycle as the tree's in_values
in_last  in  1  final beat of group, same cycle as in_values; ignored when in_valid=0
sum_value  in  BIT_WIDTH  tree output (arrives ADD_DEPTH cycles after its inputs)
out_valid  out  1  output register holds a result
out_ready  in  1  consumer accepts the result when out_valid && out_ready
out_sum  out  ACC_WIDTH  group total, saturated
out_count  out  CNT_WIDTH  beats in group, saturated
out_overflow  out  1  sum or count saturated within this group
overrun  out  1  one-cycle pulse: completed group dropped because the output register was full

Behaviour:
- One clock domain; synchronous active-high reset on `reset`. All outputs reset to 0.
- Sideband delay: {in_valid, in_last} pass through an ADD_DEPTH-stage register chain, giving a_valid/a_last aligned with sum_value. For ADD_DEPTH=0 the chain is a wire. Reset clears every stage, so no stale beat survives reset.
- Accumulator state: acc (ACC_WIDTH), cnt (CNT_WIDTH), ovf (1), all reset to 0.
- On a_valid:
  - nsum = acc + zero-extended sum_value, computed at ACC_WIDTH+1 bits. If the carry is set, clamp to 2^ACC_WIDTH-1 and set ovf.
  - ncnt = cnt+1, clamped at 2^CNT_WIDTH-1; a clamp sets ovf.
- a_valid && !a_last: acc<=nsum, cnt<=ncnt, ovf<=ovf_next.
- a_valid && a_last (group complete):
  - Final values are nsum/ncnt/ovf_next, including the current beat.
  - acc, cnt and ovf clear to 0 on the same edge.
  - If !out_valid, or out_valid && out_ready in this cycle, load the output register with the final values and set out_valid=1.
  - Otherwise the result is dropped, overrun=1 for one cycle, and the output register is unchanged.
- !a_valid: the accumulator holds (gaps inside a group are legal).
- Output register: out_valid clears on an out_valid && out_ready handshake with no simultaneous load. A simultaneous accept and load is back-to-back and keeps out_valid=1 with the new data. out_* stay stable while out_valid && !out_ready.
- Latency: the beat with in_last at cycle t gives out_valid=1 at cycle t+ADD_DEPTH+1.
- The block cannot stall upstream because the tree has no enable. Backpressure is reported only via overrun.
- Reset mid-group discards the partial group, the delay-line contents and any pending output.

Decomposition:
- Shared common include: the ceil-log2 constant function already used by the LSD common blocks, so that ADD_DEPTH is computed identically here and in the tree.
- One natural sub-module, `sideband_delay` (parameters DEPTH, WIDTH), with reset: a DEPTH-stage register chain that degenerates to a wire at DEPTH=0.
- Accumulator and output register stay in the top module.

Test Plan:
- Basic group (IN_NUM=4 → delay 2, BIT_WIDTH=8, ACC=16): drive valid beats whose sums are 10, 20, 30, with last on the third beat at cycle t, out_ready=1 → out_valid at t+3 with out_sum=60, out_count=3, out_overflow=0.
- Gaps and single beat: beats 5, gap, gap, 7(last), then an immediate single beat 9(last) → results 12/2, then 9/1, on consecutive group boundaries with no mixing.
- Saturation (ACC_WIDTH=12): 17 beats of 255 → out_sum=4095, out_count=17, out_overflow=1. The next group of 1 → out_overflow=0.
- Backpressure: hold out_ready=0 with result 60 pending, complete another group → overrun pulses for 1 cycle and out_sum stays 60. With out_ready=1 on the completion cycle instead → back-to-back load and no overrun.
- Reset mid-group: 2 beats of 100, assert reset for one cycle, then a group of 3 (last) → out_sum=3, out_count=1, no residue. Separately, drive in_valid one cycle before reset → no output afterwards.
- IN_NUM=1 (delay 0): beat 42 with last at t → out_valid at t+1, out_sum=42.
